wallace_mac_accumulator: RTL and testbench
==========================================

Name: wallace_mac_accumulator

Overview:
Downstream consumer of the 4x4 Wallace tree multiplier (signed 4-bit A × unsigned 4-bit B → signed 8-bit product). It accepts a stream of product beats over a valid/ready handshake and accumulates one vector into a sign-extended accumulator. A vector ends on prod_last or after MAX_LEN beats; the block then presents the dot-product result, beat count and overflow flag on a valid/ready output handshake. It forms the accumulate half of the team's MAC datapath.

Parameters:
ACC_W, 16, accumulator/result width in bits; must be >= 8.
MAX_LEN, 16, maximum beats per vector; the vector force-terminates at this count.
CNT_W, 5, width of res_count; must represent MAX_LEN.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
prod  input  8  signed two's-complement product from the multiplier z output.
prod_valid  input  1  prod and prod_last are valid.
prod_last  input  1  current beat is the last of the vector.
prod_ready  output  1  block can accept a beat; registered.
res  output  ACC_W  signed accumulated result.
res_count  output  CNT_W  number of beats in the reported vector (1..MAX_LEN).
res_ovf  output  1  sticky signed-overflow flag for the reported vector.
res_valid  output  1  res, res_count and res_ovf are valid.
res_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (async, while rst=1): state=IDLE, acc=0, count=0, ovf=0; prod_ready=0, res=0, res_count=0, res_ovf=0, res_valid=0. prod_ready rises at the first clock edge after rst deasserts.
- A beat is accepted on a rising edge where prod_valid=1 and prod_ready=1. prod_valid without prod_ready is ignored; no data is lost or duplicated.
- States:
  - IDLE: no vector is open.
  - ACC: a vector is open; acc holds the partial sum.
  - HOLD: result presented; prod_ready=0.
- Accept in IDLE: acc <= sext(prod); count <= 1; ovf <= 0.
- Accept in ACC: acc <= acc + sext(prod); count <= count+1; ovf |= signed overflow of that add.
- sext: bit 7 of prod is replicated up to ACC_W. Addition is ACC_W-bit two's complement. Overflow means both operands have the same sign and the sum sign differs.
- Termination: if the accepted beat has prod_last=1, or count+1 == MAX_LEN, then on the same edge:
  - state goes to HOLD;
  - res, res_count and res_ovf load the final values;
  - res_valid is set to 1 and prod_ready is cleared to 0.
  Otherwise the state is ACC.
- Latency: the result is visible the cycle after the final beat is accepted.
- HOLD: res, res_count and res_ovf are stable until the handshake (res_valid & res_ready).
  - On the handshake edge: res_valid <= 0, prod_ready <= 1, state <= IDLE, acc/count/ovf cleared.
  - A new beat is never accepted on the handshake edge; the earliest new accept is the next edge.
- res_ready is ignored when res_valid=0.
- prod_last on the MAX_LEN-th beat terminates once; it causes no double termination.
- Reset mid-vector: the partial vector is discarded and all outputs return to their reset values. A pending unacknowledged result is dropped.
- MAX_LEN=1: every beat is a one-beat vector.

Optional Feature:
Macro: WALLACE_MAC_SATURATE_EN.
- Defined: when an add overflows, acc clamps to +2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow). Saturation persists for the rest of the vector; later adds start from the clamped value. ovf is set as usual.
- Undefined: result wraps modulo 2^ACC_W. ovf is set identically.

Test Plan:
- Beats 0x0F (15), 0xF2 (-14), 0x08 last → res=0x0009, res_count=3, res_ovf=0; res_valid rises 1 cycle after the third accept.
- Result backpressure: after a vector ends, hold res_ready=0 for 5 cycles with prod_valid=1 → res stable, prod_ready=0, no beats consumed. Then res_ready=1 → handshake, prod_ready=1 next cycle, and the next beat starts a fresh sum.
- 16 beats of 0x31 (49), prod_last=0 throughout → forced termination: res=0x0310 (784), res_count=16. A 17th beat offered early waits until after the handshake.
- ACC_W=8: beats 0x69, 0x69 last → without the macro res=0xD2, res_ovf=1; with WALLACE_MAC_SATURATE_EN res=0x7F, res_ovf=1.
- Single beat 0x88 (-120) with prod_last=1 → res=0xFF88, res_count=1, res_ovf=0.
- Two beats accepted, then rst pulsed for 1 cycle → res_valid=0 and prod_ready=0 during reset. Next vector 0x05 last → res=0x0005, res_count=1.

Source files
------------

// File: rtl/wallace_mac_if.sv
// Handshake bundle between the Wallace multiplier stream, the MAC accumulator and its result consumer.
interface wallace_mac_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 5
);
  logic [7:0]       prod;
  logic             prod_valid;
  logic             prod_last;
  logic             prod_ready;
  logic [ACC_W-1:0] res;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;
  logic             res_valid;
  logic             res_ready;

  // master drives products and consumes results; slave is the accumulator
  modport master (
    output prod, prod_valid, prod_last, res_ready,
    input  prod_ready, res, res_count, res_ovf, res_valid
  );
  modport slave (
    input  prod, prod_valid, prod_last, res_ready,
    output prod_ready, res, res_count, res_ovf, res_valid
  );
endinterface

// File: rtl/wallace_mac_accumulator.sv
// Accumulates signed 8-bit product beats into one dot-product result per vector.
// Optional macro WALLACE_MAC_SATURATE_EN clamps the accumulator on signed overflow.
module wallace_mac_accumulator #(
  parameter int ACC_W   = 16,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic          clk,
  input  logic          rst,
  wallace_mac_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic             ovf_q, ovf_d, rovf_q, rovf_d;
  logic             rdy_q, rdy_d, rvld_q, rvld_d;

  logic             accept, hshk, add_ovf, ovf_new, term;
  logic [ACC_W-1:0] base, addend, sum, acc_new;
  logic [CNT_W-1:0] cnt_new;

  assign accept  = bus.prod_valid && rdy_q;
  assign hshk    = rvld_q && bus.res_ready;
  assign base    = (state_q == ACC) ? acc_q : '0;
  assign addend  = ACC_W'($signed(bus.prod));
  assign sum     = base + addend;
  assign add_ovf = (base[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
  assign ovf_new = ((state_q == ACC) && ovf_q) || add_ovf;
  assign cnt_new = ((state_q == ACC) ? cnt_q : '0) + CNT_W'(1);
  assign term    = accept && (bus.prod_last || (cnt_new == CNT_W'(MAX_LEN)));

`ifdef WALLACE_MAC_SATURATE_EN
  // overflow direction follows the common operand sign
  assign acc_new = !add_ovf      ? sum :
                   base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                   {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign acc_new = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      res_q   <= '0;
      rcnt_q  <= '0;
      rovf_q  <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
      rovf_q  <= rovf_d;
      rvld_q  <= rvld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: if (accept) state_d = term ? HOLD : ACC;
      HOLD:      if (hshk)   state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    res_d  = res_q;
    rcnt_d = rcnt_q;
    rovf_d = rovf_q;
    rvld_d = rvld_q;
    // ready is held low only while a result waits; no accept on the handshake edge
    rdy_d  = (state_q != HOLD);
    if (accept) begin
      acc_d = acc_new;
      cnt_d = cnt_new;
      ovf_d = ovf_new;
    end
    if (term) begin
      res_d  = acc_new;
      rcnt_d = cnt_new;
      rovf_d = ovf_new;
      rvld_d = 1'b1;
      rdy_d  = 1'b0;
    end else if (hshk) begin
      acc_d  = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      rvld_d = 1'b0;
      rdy_d  = 1'b1;
    end
  end

  assign bus.prod_ready = rdy_q;
  assign bus.res        = res_q;
  assign bus.res_count  = rcnt_q;
  assign bus.res_ovf    = rovf_q;
  assign bus.res_valid  = rvld_q;
endmodule

// File: tb/tb_wallace_mac_accumulator.sv
// Directed bench: a 16-bit accumulator instance plus an 8-bit one for overflow corners.
module tb_wallace_mac_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wallace_mac_if #(.ACC_W(16), .CNT_W(5)) b ();
  wallace_mac_if #(.ACC_W(8),  .CNT_W(5)) e ();

  wallace_mac_accumulator #(.ACC_W(16), .MAX_LEN(16), .CNT_W(5)) dut16 (.clk(clk), .rst(rst), .bus(b));
  wallace_mac_accumulator #(.ACC_W(8),  .MAX_LEN(16), .CNT_W(5)) dut8  (.clk(clk), .rst(rst), .bus(e));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // offer one beat, wait (bounded) for acceptance, end at the following negedge
  task automatic beat(input bit sel, input logic [7:0] p, input logic last);
    int n = 0;
    if (sel) begin e.prod = p; e.prod_last = last; e.prod_valid = 1'b1; end
    else     begin b.prod = p; b.prod_last = last; b.prod_valid = 1'b1; end
    while (!(sel ? e.prod_ready : b.prod_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    if (sel) e.prod_valid = 1'b0; else b.prod_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic ack(input bit sel);
    if (sel) e.res_ready = 1'b1; else b.res_ready = 1'b1;
    @(posedge clk);
    #1;
    if (sel) e.res_ready = 1'b0; else b.res_ready = 1'b0;
    @(negedge clk);
    chk("ack_valid_clear", 64'(sel ? e.res_valid : b.res_valid), 64'd0);
  endtask

  initial begin
    b.prod = '0; b.prod_valid = 1'b0; b.prod_last = 1'b0; b.res_ready = 1'b0;
    e.prod = '0; e.prod_valid = 1'b0; e.prod_last = 1'b0; e.res_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_prod_ready", 64'(b.prod_ready), 64'd0);
    chk("rst_res",        64'(b.res),        64'd0);
    chk("rst_res_count",  64'(b.res_count),  64'd0);
    chk("rst_res_ovf",    64'(b.res_ovf),    64'd0);
    chk("rst_res_valid",  64'(b.res_valid),  64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(b.prod_ready), 64'd1);

    // 15 - 14 + 8 = 9
    beat(0, 8'h0F, 1'b0);
    beat(0, 8'hF2, 1'b0);
    chk("basic_valid_early", 64'(b.res_valid), 64'd0);
    beat(0, 8'h08, 1'b1);
    chk("basic_valid", 64'(b.res_valid), 64'd1);
    chk("basic_res",   64'(b.res),       64'h0009);
    chk("basic_count", 64'(b.res_count), 64'd3);
    chk("basic_ovf",   64'(b.res_ovf),   64'd0);

    // backpressure: a pending beat must not be consumed while the result waits
    b.prod = 8'h11; b.prod_last = 1'b1; b.prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_res",        64'(b.res),        64'h0009);
      chk("bp_prod_ready", 64'(b.prod_ready), 64'd0);
      chk("bp_valid",      64'(b.res_valid),  64'd1);
    end
    b.res_ready = 1'b1;
    @(posedge clk);
    #1;
    b.res_ready = 1'b0;
    @(negedge clk);
    chk("bp_hs_valid", 64'(b.res_valid),  64'd0);
    chk("bp_hs_ready", 64'(b.prod_ready), 64'd1);
    @(posedge clk);
    #1;
    b.prod_valid = 1'b0;
    @(negedge clk);
    chk("bp_fresh_res",   64'(b.res),       64'h0011);
    chk("bp_fresh_count", 64'(b.res_count), 64'd1);
    chk("bp_fresh_valid", 64'(b.res_valid), 64'd1);
    ack(0);

    // forced termination at MAX_LEN: 16 * 49 = 784
    for (int i = 0; i < 16; i++) beat(0, 8'h31, 1'b0);
    chk("max_valid", 64'(b.res_valid),  64'd1);
    chk("max_res",   64'(b.res),        64'h0310);
    chk("max_count", 64'(b.res_count),  64'd16);
    chk("max_ovf",   64'(b.res_ovf),    64'd0);
    b.prod = 8'h02; b.prod_last = 1'b1; b.prod_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("max_17th_wait", 64'(b.prod_ready), 64'd0);
    chk("max_res_hold",  64'(b.res),        64'h0310);
    b.res_ready = 1'b1;
    @(posedge clk);
    #1;
    b.res_ready = 1'b0;
    @(posedge clk);
    #1;
    b.prod_valid = 1'b0;
    @(negedge clk);
    chk("max_17th_res",   64'(b.res),       64'h0002);
    chk("max_17th_count", 64'(b.res_count), 64'd1);
    ack(0);

    // single negative beat sign-extends
    beat(0, 8'h88, 1'b1);
    chk("neg_res",   64'(b.res),       64'hFF88);
    chk("neg_count", 64'(b.res_count), 64'd1);
    chk("neg_ovf",   64'(b.res_ovf),   64'd0);
    ack(0);

    // 8-bit accumulator: 105 + 105 overflows positive, -128 + -128 negative
    beat(1, 8'h69, 1'b0);
    beat(1, 8'h69, 1'b1);
`ifdef WALLACE_MAC_SATURATE_EN
    chk("ovf8_pos_res", 64'(e.res), 64'h7F);
`else
    chk("ovf8_pos_res", 64'(e.res), 64'hD2);
`endif
    chk("ovf8_pos_flag",  64'(e.res_ovf),   64'd1);
    chk("ovf8_pos_count", 64'(e.res_count), 64'd2);
    ack(1);
    beat(1, 8'h80, 1'b0);
    beat(1, 8'h80, 1'b1);
`ifdef WALLACE_MAC_SATURATE_EN
    chk("ovf8_neg_res", 64'(e.res), 64'h80);
`else
    chk("ovf8_neg_res", 64'(e.res), 64'h00);
`endif
    chk("ovf8_neg_flag", 64'(e.res_ovf), 64'd1);
    ack(1);

    // reset in the middle of a vector discards it
    beat(0, 8'h10, 1'b0);
    beat(0, 8'h20, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(b.res_valid),  64'd0);
    chk("midrst_ready", 64'(b.prod_ready), 64'd0);
    chk("midrst_res",   64'(b.res),        64'd0);
    @(negedge clk);
    rst = 1'b0;
    beat(0, 8'h05, 1'b1);
    chk("postrst_res",   64'(b.res),       64'h0005);
    chk("postrst_count", 64'(b.res_count), 64'd1);
    chk("postrst_ovf",   64'(b.res_ovf),   64'd0);
    ack(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
